// File: rtl/rdata_read_sequencer_pkg.sv
// Shared types for the rdata read-out sequencer: FSM states and the
// output FIFO entry layout (data word plus its two stream markers).
package rdata_read_sequencer_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              bank_last;
    logic              last;
  } fifo_entry_t;

endpackage

// File: rtl/rdata_read_sequencer_if.sv
// Memory read port plus output stream of the rdata read sequencer.
// master = sequencer side, slave = memory/consumer side.
interface rdata_read_sequencer_if
  import rdata_read_sequencer_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int BANK_W = 5
);

  logic              mem_read_enable;
  logic [ADDR_W-1:0] mem_read_address;
  logic [BANK_W-1:0] mem_bank;
  logic [DATA_W-1:0] mem_data;

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_bank_last;
  logic              out_last;

  modport master (
    output mem_read_enable, mem_read_address, mem_bank,
    input  mem_data,
    output out_data, out_valid, out_bank_last, out_last,
    input  out_ready
  );

  modport slave (
    input  mem_read_enable, mem_read_address, mem_bank,
    output mem_data,
    input  out_data, out_valid, out_bank_last, out_last,
    output out_ready
  );

endinterface

// File: rtl/rdata_out_fifo.sv
// Output FIFO with a registered first-word-fall-through head. The head
// register feeds the stream directly; the storage array only holds
// entries queued behind it. Occupancy counts head plus stored entries.
module rdata_out_fifo
  import rdata_read_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fifo_entry_t            push_entry,
  input  logic                   ready,
  output fifo_entry_t            head,
  output logic                   head_valid,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fifo_entry_t store_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] store_cnt_q, store_cnt_d;
  fifo_entry_t      head_q, head_d;
  logic             head_valid_q, head_valid_d;

  logic pop;
  logic head_free;
  logic load_from_store;
  logic bypass;
  logic store_we;

  // Head refill: stored entries take priority, an empty store lets a push
  // fall straight through into the head register.
  always_comb begin
    pop             = head_valid_q & ready;
    head_free       = ~head_valid_q | pop;
    load_from_store = head_free & (store_cnt_q != '0);
    bypass          = head_free & (store_cnt_q == '0) & push;
    store_we        = push & ~bypass;

    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    store_cnt_d  = store_cnt_q + CNT_W'(store_we) - CNT_W'(load_from_store);
    head_d       = head_q;
    head_valid_d = head_valid_q;

    if (store_we) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (load_from_store) begin
      rd_ptr_d     = rd_ptr_q + PTR_W'(1);
      head_d       = store_mem[rd_ptr_q];
      head_valid_d = 1'b1;
    end else if (bypass) begin
      head_d       = push_entry;
      head_valid_d = 1'b1;
    end else if (head_free) begin
      head_valid_d = 1'b0;
    end
  end

  // Storage array write; contents need no reset since pointers gate them.
  always_ff @(posedge clk) begin
    if (store_we) begin
      store_mem[wr_ptr_q] <= push_entry;
    end
  end

  // Pointer, count and head registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      store_cnt_q  <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      store_cnt_q  <= store_cnt_d;
      head_q       <= head_d;
      head_valid_q <= head_valid_d;
    end
  end

  assign head       = head_q;
  assign head_valid = head_valid_q;
  assign occupancy  = store_cnt_q + CNT_W'(head_valid_q);

endmodule

// File: rtl/rdata_read_sequencer.sv
// Walks a range of banks of the pixel store, issuing one read per cycle
// while FIFO credit allows, and streams the returned words out with
// per-bank and end-of-command markers.
module rdata_read_sequencer
  import rdata_read_sequencer_pkg::*;
#(
  parameter int MEMW_SIZE  = 3200,
  parameter int NUM_BANKS  = 24,
  parameter int ADDR_W     = 12,
  parameter int BANK_W     = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BANK_W-1:0]     bank_first,
  input  logic [BANK_W:0]       bank_count,
  output logic                  busy,
  output logic                  done,
  rdata_read_sequencer_if.master bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MEMW_SIZE - 1);
  localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(NUM_BANKS - 1);

  seq_state_e state_q, state_d;

  // addr/bank always hold the most recently issued read; the next issue
  // is derived from them, so stall cycles need no extra bookkeeping.
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [BANK_W:0]   banks_left_q, banks_left_d;
  logic              en_q, en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              inflight_q, inflight_d;
  logic              tag_bank_last_q, tag_bank_last_d;
  logic              tag_last_q, tag_last_d;

  logic [CNT_W-1:0]  occupancy;
  logic [CNT_W:0]    committed;
  logic              credit_ok;
  logic              cur_bank_last;
  logic              cur_last;
  logic              final_issue;
  fifo_entry_t       push_entry;
  fifo_entry_t       head;
  logic              head_valid;

  // Credit counts words already queued plus reads on the bus and in the
  // tag stage, so a new issue always has a FIFO slot when its data lands.
  always_comb begin
    committed     = {1'b0, occupancy} + (CNT_W+1)'(en_q) + (CNT_W+1)'(inflight_q);
    credit_ok     = committed < (CNT_W+1)'(FIFO_DEPTH);
    cur_bank_last = (addr_q == ADDR_LAST);
    cur_last      = cur_bank_last & (banks_left_q == (BANK_W+1)'(1));
    final_issue   = en_q & cur_last;
  end

  // Next-state, issue and counter logic.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    bank_d          = bank_q;
    banks_left_d    = banks_left_q;
    en_d            = 1'b0;
    busy_d          = busy_q;
    done_d          = 1'b0;
    inflight_d      = en_q;
    tag_bank_last_d = en_q & cur_bank_last;
    tag_last_d      = en_q & cur_last;

    case (state_q)
      ST_IDLE: begin
        if (start && !busy_q) begin
          if (bank_count == '0) begin
            done_d = 1'b1;
          end else begin
            // FIFO and tag stage are empty here, so the first read goes out
            // without a credit check.
            state_d      = ST_RUN;
            busy_d       = 1'b1;
            en_d         = 1'b1;
            addr_d       = '0;
            bank_d       = bank_first;
            banks_left_d = bank_count;
          end
        end
      end
      ST_RUN: begin
        if (final_issue) begin
          state_d = ST_DRAIN;
        end else if (credit_ok) begin
          en_d = 1'b1;
          if (addr_q == ADDR_LAST) begin
            addr_d       = '0;
            bank_d       = (bank_q == BANK_LAST) ? '0 : bank_q + BANK_W'(1);
            banks_left_d = banks_left_q - (BANK_W+1)'(1);
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (head_valid && bus.out_ready && head.last) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters, registered strobes and the one-stage tag pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      bank_q          <= '0;
      banks_left_q    <= '0;
      en_q            <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      inflight_q      <= 1'b0;
      tag_bank_last_q <= 1'b0;
      tag_last_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      bank_q          <= bank_d;
      banks_left_q    <= banks_left_d;
      en_q            <= en_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      inflight_q      <= inflight_d;
      tag_bank_last_q <= tag_bank_last_d;
      tag_last_q      <= tag_last_d;
    end
  end

  assign push_entry = '{data: bus.mem_data, bank_last: tag_bank_last_q, last: tag_last_q};

  rdata_out_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (inflight_q),
    .push_entry (push_entry),
    .ready      (bus.out_ready),
    .head       (head),
    .head_valid (head_valid),
    .occupancy  (occupancy)
  );

  assign bus.mem_read_enable  = en_q;
  assign bus.mem_read_address = addr_q;
  assign bus.mem_bank         = bank_q;
  assign bus.out_data         = head.data;
  assign bus.out_bank_last    = head.bank_last;
  assign bus.out_last         = head.last;
  assign bus.out_valid        = head_valid;
  assign busy                 = busy_q;
  assign done                 = done_q;

endmodule

// File: tb/tb_rdata_read_sequencer.sv
// Directed bench for rdata_read_sequencer with a small memory model
// (word = bank*256 + address) and a negedge stream monitor.
module tb_rdata_read_sequencer;

  localparam int MEMW = 8;
  localparam int NB   = 4;
  localparam int AW   = 3;
  localparam int BW   = 2;
  localparam int FD   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [BW-1:0] bank_first = '0;
  logic [BW:0]   bank_count = '0;
  logic          busy;
  logic          done;

  rdata_read_sequencer_if #(.ADDR_W(AW), .BANK_W(BW)) bus ();

  rdata_read_sequencer #(
    .MEMW_SIZE  (MEMW),
    .NUM_BANKS  (NB),
    .ADDR_W     (AW),
    .BANK_W     (BW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bank_first (bank_first),
    .bank_count (bank_count),
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Memory model with one-cycle read latency.
  always @(posedge clk) begin
    if (rst) bus.mem_data <= '0;
    else if (bus.mem_read_enable)
      bus.mem_data <= 32'(bus.mem_bank) * 32'd256 + 32'(bus.mem_read_address);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor state (written only by the monitor process).
  logic [33:0] words[$];
  int  done_cnt = 0, en_cnt = 0, busy_cnt = 0;
  int  t_start = 0, t_first_en = 0, t_first_valid = 0, t_done = 0;
  int  issued = 0, popped = 0, credit_viol = 0, hold_viol = 0;
  bit  en_pend = 0, valid_pend = 0, prev_stall = 0;
  logic [33:0] prev_head = '0;

  initial begin
    logic [33:0] cur;
    forever begin
      @(negedge clk);
      cur = {bus.out_data, bus.out_bank_last, bus.out_last};
      if (rst) begin
        issued = 0; popped = 0; prev_stall = 0; en_pend = 0; valid_pend = 0;
      end else begin
        if (start && !busy) begin
          t_start = cyc; en_pend = 1; valid_pend = 1;
        end
        if (bus.mem_read_enable) begin
          en_cnt++; issued++;
          if (en_pend) begin t_first_en = cyc; en_pend = 0; end
        end
        if (issued - popped > FD) credit_viol++;
        if (bus.out_valid && valid_pend) begin t_first_valid = cyc; valid_pend = 0; end
        if (prev_stall && !(bus.out_valid && cur == prev_head)) hold_viol++;
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_head  = cur;
        if (bus.out_valid && bus.out_ready) begin
          words.push_back(cur);
          popped++;
          $display("xfer cyc=%0d data=0x%08h bank_last=%0b last=%0b",
                   cyc, bus.out_data, bus.out_bank_last, bus.out_last);
        end
        if (done) begin done_cnt++; t_done = cyc; end
        if (busy) busy_cnt++;
      end
    end
  end

  function automatic logic [63:0] outs_packed();
    return 64'({busy, done, bus.mem_read_enable, bus.mem_read_address, bus.mem_bank,
                bus.out_valid, bus.out_data, bus.out_bank_last, bus.out_last});
  endfunction

  task automatic start_cmd(input int first, input int count);
    @(posedge clk); #1;
    start = 1'b1; bank_first = BW'(first); bank_count = (BW+1)'(count);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0, input int budget, input bit rand_ready);
    for (int i = 0; i < budget && done_cnt == d0; i++) begin
      @(posedge clk); #1;
      if (rand_ready) bus.out_ready = ($urandom_range(0, 99) < 30);
    end
    bus.out_ready = 1'b1;
    check_eq({tag, "_done_seen"}, 64'(done_cnt > d0), 64'd1);
  endtask

  task automatic verify_words(input string tag, input int base, input int n, input int first);
    int got_n;
    logic [31:0] exp_data;
    int b, a;
    got_n = words.size() - base;
    check_eq({tag, "_count"}, 64'(got_n), 64'(n));
    for (int i = 0; i < n && i < got_n; i++) begin
      b = (first + i / MEMW) % NB;
      a = i % MEMW;
      exp_data = 32'(b * 256 + a);
      check_eq($sformatf("%s_w%0d", tag, i), 64'(words[base + i]),
               64'({exp_data, a == MEMW - 1, i == n - 1}));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, w0, e0, b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("reset_outs", outs_packed(), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(posedge clk);

    // S1: one bank, full throughput, exact timing
    d0 = done_cnt; w0 = words.size();
    start_cmd(1, 1);
    wait_done("s1", d0, 100, 1'b0);
    verify_words("s1", w0, 8, 1);
    check_eq("s1_first_en_lat", 64'(t_first_en - t_start), 64'd1);
    check_eq("s1_first_valid_lat", 64'(t_first_valid - t_start), 64'd3);
    check_eq("s1_done_lat", 64'(t_done - t_start), 64'd11);
    @(negedge clk);
    check_eq("s1_busy_after", 64'(busy), 64'd0);

    // S2: three banks wrapping 2,3,0
    d0 = done_cnt; w0 = words.size();
    start_cmd(2, 3);
    wait_done("s2", d0, 200, 1'b0);
    verify_words("s2", w0, 24, 2);
    check_eq("s2_done_lat", 64'(t_done - t_start), 64'd27);

    // S3: random backpressure, two banks 3,0
    d0 = done_cnt; w0 = words.size();
    start_cmd(3, 2);
    wait_done("s3", d0, 2000, 1'b1);
    verify_words("s3", w0, 16, 3);
    check_eq("s3_credit_viol", 64'(credit_viol), 64'd0);
    check_eq("s3_hold_viol", 64'(hold_viol), 64'd0);

    // S4: zero banks
    repeat (2) @(posedge clk);
    d0 = done_cnt; w0 = words.size(); e0 = en_cnt; b0 = busy_cnt;
    start_cmd(0, 0);
    wait_done("s4", d0, 20, 1'b0);
    repeat (4) @(posedge clk);
    check_eq("s4_done_lat", 64'(t_done - t_start), 64'd1);
    check_eq("s4_no_reads", 64'(en_cnt - e0), 64'd0);
    check_eq("s4_busy_le1", 64'((busy_cnt - b0) <= 1), 64'd1);
    check_eq("s4_no_words", 64'(words.size() - w0), 64'd0);

    // S5: second start while busy is ignored
    d0 = done_cnt; w0 = words.size();
    start_cmd(0, 1);
    repeat (2) @(posedge clk);
    start_cmd(2, 3);
    wait_done("s5", d0, 100, 1'b0);
    repeat (30) @(posedge clk);
    check_eq("s5_one_done", 64'(done_cnt - d0), 64'd1);
    verify_words("s5", w0, 8, 0);

    // S6: reset mid-run, then a clean run
    d0 = done_cnt; w0 = words.size();
    start_cmd(1, 2);
    for (int i = 0; i < 50 && (words.size() - w0) < 5; i++) @(posedge clk);
    check_eq("s6_reached_5", 64'((words.size() - w0) >= 5), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_eq("s6_rst_async_outs", outs_packed(), 64'd0);
    @(negedge clk);
    check_eq("s6_rst_outs", outs_packed(), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("s6_no_done_abort", 64'(done_cnt - d0), 64'd0);
    repeat (2) @(posedge clk);
    d0 = done_cnt; w0 = words.size();
    start_cmd(2, 1);
    wait_done("s6", d0, 100, 1'b0);
    verify_words("s6", w0, 8, 2);
    check_eq("s6_done_lat", 64'(t_done - t_start), 64'd11);
    check_eq("s6_credit_viol", 64'(credit_viol), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
